traffic_sensor_conditioner: RTL and testbench
=============================================

# traffic_sensor_conditioner

Front-end stage for the two-road traffic light controller. Converts raw, asynchronous vehicle-loop detector inputs into the clean `Ta`/`Tb` traffic-present signals the controller's FSM consumes. Each channel provides:
- synchronisation and debounce on arrival;
- a presence hold after the vehicle leaves, so short gaps do not end the green;
- stuck-detector fault handling. A jammed loop forces its `T` output low, so the controller never parks on one road.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: consecutive-sample qualification length for arrival and fault recovery (≥1).
- `HOLD_CYCLES`, default 250000: presence stretch after the loop clears (≥1).
- `STUCK_CYCLES`, default 500000000: continuous-presence limit before fault (> `DEBOUNCE_CYCLES`).
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `loop_a`  in  1  raw road-A detector, asynchronous to `clk`.
- `loop_b`  in  1  raw road-B detector, asynchronous to `clk`.
- `Ta`  out  1  conditioned road-A traffic present.
- `Tb`  out  1  conditioned road-B traffic present.
- `fault_a`  out  1  road-A detector stuck.
- `fault_b`  out  1  road-B detector stuck.

## Operation
- **Channels:** two identical, fully independent channels (A, B). Each channel has:
  - a 2-flop synchroniser, `s1 <= loop`, `s2 <= s1`. The FSM samples `s2` ("sample" below).
  - one 32-bit counter `cnt`.
  - a 5-state FSM: ABSENT, ARMING, PRESENT, HOLD, FAULT.
- **Outputs:**
  - `T` = 1 in PRESENT or HOLD; 0 otherwise.
  - `fault` = 1 in FAULT only.
  - Both outputs are decoded from registered state only, with no input-to-output combinational path.
- **ABSENT:**
  - high sample → ARMING, `cnt`=1.
  - low sample → stay.
- **ARMING:**
  - low sample → ABSENT.
  - high sample with `cnt`==`DEBOUNCE_CYCLES` → PRESENT, `cnt`=0.
  - other high sample → `cnt`+1.
  - Net rule: `DEBOUNCE_CYCLES`+1 consecutive high samples are required to assert; `DEBOUNCE_CYCLES` high samples are rejected.
- **PRESENT:**
  - low sample → HOLD, `cnt`=1.
  - high sample with `cnt`==`STUCK_CYCLES` → FAULT, `cnt`=0.
  - other high sample → `cnt`+1.
- **HOLD:**
  - high sample → PRESENT, `cnt`=0. The stuck count restarts; `T` stays 1 with no dip.
  - low sample with `cnt`==`HOLD_CYCLES` → ABSENT.
  - other low sample → `cnt`+1.
- **FAULT:**
  - high sample → `cnt`=0.
  - low sample with `cnt`==`DEBOUNCE_CYCLES` → ABSENT; `fault` clears.
  - other low sample → `cnt`+1.
  - FAULT exits only via `DEBOUNCE_CYCLES`+1 consecutive low samples, or via reset.
- **Counter width:** `cnt` is 32-bit unsigned and never wraps. Every terminal compare happens before overflow for any legal parameter value (all parameters < 2^32).
- **Reset:** `rst` asynchronously forces the following, regardless of current state, including mid-ARMING, mid-HOLD and FAULT:
  - `s1`, `s2` = 0;
  - state = ABSENT;
  - `cnt` = 0;
  - `Ta`, `Tb`, `fault_a`, `fault_b` = 0.
- **Channel independence:** a fault, reset-free activity, or any state on one channel has no effect on the other channel.

## Timing
Edges below are numbered from the first `clk` edge at which the raw loop is sampled at its new level by `s1`.
- **Arrival latency:** loop rises at edge k and stays high → `T` rises after edge k+2+`DEBOUNCE_CYCLES`.
- **Departure latency:** loop falls at edge m and stays low → `T` falls after edge m+2+`HOLD_CYCLES`.
- **Fault entry:** PRESENT entered at edge p with the loop continuously high → FAULT after edge p+1+`STUCK_CYCLES`. `T` falls and `fault` rises on that same edge.
- **Fault recovery:** loop falls at edge n while in FAULT → `fault` falls after edge n+2+`DEBOUNCE_CYCLES`. `T` remains 0 throughout.
- **Glitch handling:** a single-cycle low glitch during PRESENT gives HOLD for one cycle, then PRESENT; `T` stays constant.
- **Reset release:** the first active edge after `rst` deassertion evaluates ABSENT normally.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `HOLD_CYCLES`=8, `STUCK_CYCLES`=20.
1. **Reset:** assert `rst` with both loops high and both channels in PRESENT → all four outputs 0 immediately, with no clock edge. Release `rst` with loops high at edge 0 → `Ta`, `Tb` rise after edge 6.
2. **Glitch rejection:** `loop_a` high for exactly 4 cycles from edge 10 → `Ta` stays 0. The same stimulus with 5 cycles → `Ta`=1 after edge 16.
3. **Arrival/departure:** `loop_a` high from edge 10, low from edge 25 → `Ta` rises after edge 16 and falls after edge 35. `fault_a` stays 0.
4. **Hold retrigger:** `Ta`=1; `loop_a` low for 5 cycles, then high again → `Ta` never deasserts. A subsequent low of 9+ cycles deasserts `Ta` exactly 10 edges after the first low sample by `s1`.
5. **Stuck detector:** `loop_b` held high from edge 0:
   - `Tb`=1 after edge 6.
   - `Tb`=0 and `fault_b`=1 after edge 27.
   - Release at edge 40 → `fault_b`=0 after edge 46, with `Tb` still 0.
   - A re-arrival then follows the normal scenario-2 timing.
6. **Independence:** channel B faulted as in scenario 5 while `loop_a` runs scenario 3 concurrently → `Ta` timing is identical to scenario 3, and `fault_a`=0 throughout.

Source files
------------

// File: rtl/traffic_sensor_conditioner.sv
// Loop-detector conditioner for the two-road traffic light controller.
// Synchronises, debounces, holds and fault-guards each road's detector.

module traffic_sensor_channel #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned HOLD_CYCLES     = 250000,
    parameter int unsigned STUCK_CYCLES    = 500000000
) (
    input  logic clk,
    input  logic rst,
    input  logic loop,
    output logic t,
    output logic fault
);

    typedef enum logic [2:0] {
        ABSENT,
        ARMING,
        PRESENT,
        HOLD,
        FAULT
    } state_t;

    state_t      state;
    logic        s1;
    logic        s2;
    logic [31:0] cnt;

    // Synchroniser, channel FSM and registered outputs in one process.
    // Each transition sets t/fault so both track the registered state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            state <= ABSENT;
            cnt   <= '0;
            t     <= 1'b0;
            fault <= 1'b0;
        end else begin
            s1 <= loop;
            s2 <= s1;
            case (state)
                ABSENT: begin
                    if (s2) begin
                        state <= ARMING;
                        cnt   <= 32'd1;
                    end
                end
                ARMING: begin
                    if (!s2) begin
                        state <= ABSENT;
                        cnt   <= '0;
                    end else if (cnt == DEBOUNCE_CYCLES) begin
                        state <= PRESENT;
                        cnt   <= '0;
                        t     <= 1'b1;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                PRESENT: begin
                    if (!s2) begin
                        state <= HOLD;
                        cnt   <= 32'd1;
                    end else if (cnt == STUCK_CYCLES) begin
                        state <= FAULT;
                        cnt   <= '0;
                        t     <= 1'b0;
                        fault <= 1'b1;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                HOLD: begin
                    if (s2) begin
                        // Vehicle back: restart the stuck count, T stays high.
                        state <= PRESENT;
                        cnt   <= '0;
                    end else if (cnt == HOLD_CYCLES) begin
                        state <= ABSENT;
                        cnt   <= '0;
                        t     <= 1'b0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                FAULT: begin
                    if (s2) begin
                        cnt <= '0;
                    end else if (cnt == DEBOUNCE_CYCLES) begin
                        state <= ABSENT;
                        cnt   <= '0;
                        fault <= 1'b0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: begin
                    state <= ABSENT;
                    cnt   <= '0;
                    t     <= 1'b0;
                    fault <= 1'b0;
                end
            endcase
        end
    end

endmodule

module traffic_sensor_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned HOLD_CYCLES     = 250000,
    parameter int unsigned STUCK_CYCLES    = 500000000
) (
    input  logic clk,
    input  logic rst,
    input  logic loop_a,
    input  logic loop_b,
    output logic Ta,
    output logic Tb,
    output logic fault_a,
    output logic fault_b
);

    traffic_sensor_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .STUCK_CYCLES    (STUCK_CYCLES)
    ) u_chan_a (
        .clk   (clk),
        .rst   (rst),
        .loop  (loop_a),
        .t     (Ta),
        .fault (fault_a)
    );

    traffic_sensor_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .STUCK_CYCLES    (STUCK_CYCLES)
    ) u_chan_b (
        .clk   (clk),
        .rst   (rst),
        .loop  (loop_b),
        .t     (Tb),
        .fault (fault_b)
    );

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Scoreboard bench for traffic_sensor_conditioner.
// Expected output levels are queued per edge and checked on negedge.

module tb_traffic_sensor_conditioner;

    localparam int DEB  = 4;
    localparam int HLD  = 8;
    localparam int STK  = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic loop_a = 1'b0;
    logic loop_b = 1'b0;
    logic Ta, Tb, fault_a, fault_b;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc;

    typedef struct {
        int    cyc;
        int    sig;
        logic  val;
        string tag;
    } exp_t;

    exp_t sb[$];

    traffic_sensor_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HLD),
        .STUCK_CYCLES    (STK)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .loop_a  (loop_a),
        .loop_b  (loop_b),
        .Ta      (Ta),
        .Tb      (Tb),
        .fault_a (fault_a),
        .fault_b (fault_b)
    );

    always #5 clk = ~clk;

    // Edge index: 0 is the first rising edge after reset release.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= -1;
        else     cyc <= cyc + 1;
    end

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic out_bit(int sig);
        logic [3:0] v;
        v = {fault_b, fault_a, Tb, Ta};
        return v[sig];
    endfunction

    function automatic string sig_name(int sig);
        case (sig)
            0: return "Ta";
            1: return "Tb";
            2: return "fault_a";
            default: return "fault_b";
        endcase
    endfunction

    // Queue one expected level for every edge in [from, to].
    task automatic expect_range(string tag, int sig, int from, int to,
                                logic val);
        exp_t e;
        for (int c = from; c <= to; c++) begin
            e.cyc = c;
            e.sig = sig;
            e.val = val;
            e.tag = $sformatf("%s_%s@%0d", tag, sig_name(sig), c);
            sb.push_back(e);
        end
    endtask

    // Pop and compare every entry due at the edge just taken.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc <= cyc) begin
                    check(sb[i].tag, 32'(out_bit(sb[i].sig)),
                          32'(sb[i].val));
                    sb.delete(i);
                end
            end
        end
    end

    task automatic wait_cyc(int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Drive a loop so that s1 first samples the new level at edge k.
    task automatic drive(int k, bit chan_b, logic val);
        wait_cyc(k - 1);
        if (chan_b) loop_b = val;
        else        loop_a = val;
    endtask

    task automatic do_reset(logic a, logic b);
        @(negedge clk);
        rst    = 1'b1;
        loop_a = a;
        loop_b = b;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic async_reset_check(string tag);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check({tag, "_Ta"}, 32'(Ta), 0);
        check({tag, "_Tb"}, 32'(Tb), 0);
        check({tag, "_fault_a"}, 32'(fault_a), 0);
        check({tag, "_fault_b"}, 32'(fault_b), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset release with both loops high, then async reset from PRESENT.
        do_reset(1'b1, 1'b1);
        expect_range("rst", 0, 0, 5, 1'b0);
        expect_range("rst", 0, 6, 10, 1'b1);
        expect_range("rst", 1, 0, 5, 1'b0);
        expect_range("rst", 1, 6, 10, 1'b1);
        wait_cyc(12);
        async_reset_check("rst_present");

        // Four high cycles are rejected.
        do_reset(1'b0, 1'b0);
        expect_range("glitch4", 0, 0, 25, 1'b0);
        drive(10, 1'b0, 1'b1);
        drive(14, 1'b0, 1'b0);
        wait_cyc(27);

        // Five high cycles qualify; hold stretches the short visit.
        do_reset(1'b0, 1'b0);
        expect_range("glitch5", 0, 0, 15, 1'b0);
        expect_range("glitch5", 0, 16, 24, 1'b1);
        expect_range("glitch5", 0, 25, 28, 1'b0);
        drive(10, 1'b0, 1'b1);
        drive(15, 1'b0, 1'b0);
        wait_cyc(30);

        // Arrival and departure.
        do_reset(1'b0, 1'b0);
        expect_range("arr", 0, 0, 15, 1'b0);
        expect_range("arr", 0, 16, 34, 1'b1);
        expect_range("arr", 0, 35, 40, 1'b0);
        expect_range("arr", 2, 0, 40, 1'b0);
        drive(10, 1'b0, 1'b1);
        drive(25, 1'b0, 1'b0);
        wait_cyc(42);

        // Hold retrigger, then a long gap ends presence.
        do_reset(1'b0, 1'b0);
        expect_range("retrig", 0, 0, 15, 1'b0);
        expect_range("retrig", 0, 16, 49, 1'b1);
        expect_range("retrig", 0, 50, 55, 1'b0);
        drive(10, 1'b0, 1'b1);
        drive(20, 1'b0, 1'b0);
        drive(25, 1'b0, 1'b1);
        drive(40, 1'b0, 1'b0);
        wait_cyc(57);

        // Stuck detector on B alone, then re-arrival.
        do_reset(1'b0, 1'b1);
        expect_range("stuck", 1, 0, 5, 1'b0);
        expect_range("stuck", 1, 6, 26, 1'b1);
        expect_range("stuck", 1, 27, 55, 1'b0);
        expect_range("stuck", 1, 56, 60, 1'b1);
        expect_range("stuck", 3, 0, 26, 1'b0);
        expect_range("stuck", 3, 27, 45, 1'b1);
        expect_range("stuck", 3, 46, 60, 1'b0);
        expect_range("stuck", 0, 0, 60, 1'b0);
        drive(40, 1'b1, 1'b0);
        drive(50, 1'b1, 1'b1);
        wait_cyc(62);

        // B faults while A runs arrival/departure concurrently.
        do_reset(1'b0, 1'b1);
        expect_range("indep", 0, 0, 15, 1'b0);
        expect_range("indep", 0, 16, 34, 1'b1);
        expect_range("indep", 0, 35, 60, 1'b0);
        expect_range("indep", 2, 0, 60, 1'b0);
        expect_range("indep", 1, 6, 26, 1'b1);
        expect_range("indep", 1, 27, 55, 1'b0);
        expect_range("indep", 3, 0, 26, 1'b0);
        expect_range("indep", 3, 27, 45, 1'b1);
        expect_range("indep", 3, 46, 55, 1'b0);
        drive(10, 1'b0, 1'b1);
        drive(25, 1'b0, 1'b0);
        drive(40, 1'b1, 1'b0);
        wait_cyc(62);

        // Async reset out of FAULT.
        do_reset(1'b0, 1'b1);
        expect_range("fltrst", 3, 27, 30, 1'b1);
        wait_cyc(32);
        async_reset_check("rst_fault");

        do_reset(1'b0, 1'b0);
        check("sb_empty", 32'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
